// File: rtl/bundle_ctrl.sv
// bundle_ctrl: sequencer for a bank of per-lane HDC bundling counters.
// It accepts a stream of D-bit items and drives the bank's accumulate and
// clear strobes. When a bundle has an even item count it applies one
// tie-break strobe. It then captures the bank's sign bits into a
// valid/ready result handshake.
module bundle_ctrl #(
  parameter int D = 32,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [D-1:0] s_data,
  input  logic         s_last,
  input  logic [D-1:0] tb_vec,
  output logic [D-1:0] ctr_bit,
  output logic         ctr_k_fin,
  output logic         ctr_s_fin,
  input  logic [D-1:0] ctr_sign,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [D-1:0] m_data,
  output logic [W-1:0] m_count,
  output logic         busy,
  output logic         err_ovf
);

  // Item cap: keeps count+1 (including the tie-break) inside signed W range.
  localparam logic [W-1:0] CAP = W'((2 ** (W - 1)) - 2);

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_TIEBRK = 3'd2,
    ST_SETTLE = 3'd3,
    ST_OUTPUT = 3'd4
  } state_t;

  state_t       state_q;
  logic [W-1:0] count_q;
  logic         settle_q;
  logic [D-1:0] ctr_bit_q;
  logic         ctr_k_fin_q;
  logic         ctr_s_fin_q;
  logic         s_ready_q;
  logic         m_valid_q;
  logic [D-1:0] m_data_q;
  logic [W-1:0] m_count_q;
  logic         busy_q;
  logic         err_ovf_q;

  logic         room_s;
  logic [W-1:0] count_d;

  // Room check and the item count that results if the current item is accepted.
  always_comb begin
    room_s = (count_q < CAP);
    if (room_s) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Main sequencer: state plus all registered outputs and strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      count_q     <= {W{1'b0}};
      settle_q    <= 1'b0;
      ctr_bit_q   <= {D{1'b0}};
      ctr_k_fin_q <= 1'b0;
      ctr_s_fin_q <= 1'b0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= {D{1'b0}};
      m_count_q   <= {W{1'b0}};
      busy_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      ctr_k_fin_q <= 1'b0;
      ctr_s_fin_q <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          ctr_s_fin_q <= 1'b1;
          count_q     <= {W{1'b0}};
          settle_q    <= 1'b0;
          s_ready_q   <= 1'b1;
          state_q     <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (s_valid && s_ready_q) begin
            busy_q <= 1'b1;
            if (room_s) begin
              ctr_bit_q   <= s_data;
              ctr_k_fin_q <= 1'b1;
              count_q     <= count_d;
            end else begin
              err_ovf_q <= 1'b1;
            end
            if (s_last) begin
              s_ready_q <= 1'b0;
              // Even number of votes can tie, so add one tie-break vote.
              if (count_d[0] == 1'b0) begin
                state_q <= ST_TIEBRK;
              end else begin
                state_q <= ST_SETTLE;
              end
            end else begin
              state_q <= ST_ACCUM;
            end
          end else begin
            state_q <= ST_ACCUM;
          end
        end
        ST_TIEBRK: begin
          ctr_bit_q   <= tb_vec;
          ctr_k_fin_q <= 1'b1;
          state_q     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // The first cycle lets the bank apply the last strobe.
          // The second cycle samples the resulting sign bits.
          if (!settle_q) begin
            settle_q <= 1'b1;
          end else begin
            settle_q  <= 1'b0;
            m_data_q  <= ctr_sign;
            m_count_q <= count_q;
            m_valid_q <= 1'b1;
            state_q   <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= ST_CLEAR;
          end else begin
            state_q <= ST_OUTPUT;
          end
        end
        default: begin
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
          state_q   <= ST_CLEAR;
        end
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign ctr_bit   = ctr_bit_q;
  assign ctr_k_fin = ctr_k_fin_q;
  assign ctr_s_fin = ctr_s_fin_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_count   = m_count_q;
  assign busy      = busy_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_bundle_ctrl.sv
// Directed testbench for bundle_ctrl. It uses a behavioural counter bank
// and two instances: W=16 and W=4. The W=4 instance exercises the item cap.
module tb_bundle_ctrl;

  localparam int D = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // W=16 instance
  logic         s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [D-1:0] s_data = '0, tb_vec = '0;
  logic         s_ready, ctr_k_fin, ctr_s_fin, m_valid, busy, err_ovf;
  logic [D-1:0] ctr_bit, ctr_sign, m_data;
  logic [15:0]  m_count;

  // W=4 instance
  logic         s_valid4 = 1'b0, s_last4 = 1'b0, m_ready4 = 1'b0;
  logic [D-1:0] s_data4 = '0, tb_vec4 = '0;
  logic         s_ready4, ctr_k_fin4, ctr_s_fin4, m_valid4, busy4, err_ovf4;
  logic [D-1:0] ctr_bit4, ctr_sign4, m_data4;
  logic [3:0]   m_count4;

  bundle_ctrl #(.D(D), .W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .tb_vec(tb_vec), .ctr_bit(ctr_bit), .ctr_k_fin(ctr_k_fin),
    .ctr_s_fin(ctr_s_fin), .ctr_sign(ctr_sign), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_count(m_count), .busy(busy), .err_ovf(err_ovf)
  );

  bundle_ctrl #(.D(D), .W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
    .s_last(s_last4), .tb_vec(tb_vec4), .ctr_bit(ctr_bit4), .ctr_k_fin(ctr_k_fin4),
    .ctr_s_fin(ctr_s_fin4), .ctr_sign(ctr_sign4), .m_valid(m_valid4), .m_ready(m_ready4),
    .m_data(m_data4), .m_count(m_count4), .busy(busy4), .err_ovf(err_ovf4)
  );

  // Reference counter banks: bit 0 -> +1, bit 1 -> -1, sign = MSB
  logic [15:0] bank16 [D];
  logic [3:0]  bank4  [D];
  int kfin4_cnt = 0;

  always @(posedge clk) begin
    for (int i = 0; i < D; i++) begin
      if (ctr_s_fin) bank16[i] <= 16'd0;
      else if (ctr_k_fin) bank16[i] <= ctr_bit[i] ? bank16[i] - 16'd1 : bank16[i] + 16'd1;
    end
  end

  always @(posedge clk) begin
    for (int j = 0; j < D; j++) begin
      if (ctr_s_fin4) bank4[j] <= 4'd0;
      else if (ctr_k_fin4) bank4[j] <= ctr_bit4[j] ? bank4[j] - 4'd1 : bank4[j] + 4'd1;
    end
  end

  always @(posedge clk) begin
    if (ctr_k_fin4) kfin4_cnt <= kfin4_cnt + 1;
  end

  always_comb begin
    ctr_sign  = '0;
    ctr_sign4 = '0;
    for (int k = 0; k < D; k++) begin
      ctr_sign[k]  = bank16[k][15];
      ctr_sign4[k] = bank4[k][3];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input logic last);
    s_valid = 1'b1; s_data = d; s_last = last;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic put4(input logic [31:0] d, input logic last);
    s_valid4 = 1'b1; s_data4 = d; s_last4 = last;
    tick();
    s_valid4 = 1'b0; s_last4 = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_kfin", ctr_k_fin, 1'b0);
    chk("rst_sfin", ctr_s_fin, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_ovf, 1'b0);
    chk("rst_m_count", m_count, 16'd0);
    chk("rst4_s_ready", s_ready4, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("clr_sfin", ctr_s_fin, 1'b1);
    chk("clr_s_ready", s_ready, 1'b1);
    chk("clr4_s_ready", s_ready4, 1'b1);

    // ---------------- test 1: three items, odd ----------------
    put(32'hFFFF0000, 1'b0);
    chk("t1_kfin", ctr_k_fin, 1'b1);
    chk("t1_bit", ctr_bit, 32'hFFFF0000);
    chk("t1_busy", busy, 1'b1);
    chk("t1_sfin_low", ctr_s_fin, 1'b0);
    put(32'hFF00FF00, 1'b0);
    put(32'hF0F0F0F0, 1'b1);
    chk("t1_s_ready_low", s_ready, 1'b0);
    chk("t1_last_kfin", ctr_k_fin, 1'b1);
    tick();
    chk("t1_mv_e1", m_valid, 1'b0);
    tick();
    chk("t1_mv_e2", m_valid, 1'b1);
    chk("t1_data", m_data, 32'hFFF0F000);
    chk("t1_count", m_count, 16'd3);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t1_mv_drop", m_valid, 1'b0);
    chk("t1_busy_drop", busy, 1'b0);
    tick();
    chk("t1_clr_sfin", ctr_s_fin, 1'b1);
    chk("t1_clr_ready", s_ready, 1'b1);

    // ---------------- test 2: two items, tie-break ----------------
    tb_vec = 32'h0F0F0F0F;
    put(32'hFFFF0000, 1'b0);
    put(32'h00FF00FF, 1'b1);
    chk("t2_last_kfin", ctr_k_fin, 1'b1);
    tick();
    chk("t2_tb_kfin", ctr_k_fin, 1'b1);
    chk("t2_tb_bit", ctr_bit, 32'h0F0F0F0F);
    chk("t2_mv_e1", m_valid, 1'b0);
    tick();
    chk("t2_kfin_e2", ctr_k_fin, 1'b0);
    chk("t2_mv_e2", m_valid, 1'b0);
    tick();
    chk("t2_mv_e3", m_valid, 1'b1);
    chk("t2_data", m_data, 32'h0FFF000F);
    chk("t2_count", m_count, 16'd2);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();

    // ---------------- test 3: single item, no tie-break ----------------
    tb_vec = 32'h00000000;
    put(32'hA5A5A5A5, 1'b1);
    tick();
    chk("t3_no_tb", ctr_k_fin, 1'b0);
    chk("t3_mv_e1", m_valid, 1'b0);
    tick();
    chk("t3_mv_e2", m_valid, 1'b1);
    chk("t3_data", m_data, 32'hA5A5A5A5);
    chk("t3_count", m_count, 16'd1);

    // ---------------- test 4: back-pressure ----------------
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4_hold_mv", m_valid, 1'b1);
      chk("t4_hold_data", m_data, 32'hA5A5A5A5);
      chk("t4_hold_ready", s_ready, 1'b0);
      chk("t4_hold_sfin", ctr_s_fin, 1'b0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t4_mv_drop", m_valid, 1'b0);
    chk("t4_sfin_e0", ctr_s_fin, 1'b0);
    tick();
    chk("t4_sfin_pulse", ctr_s_fin, 1'b1);
    chk("t4_ready_up", s_ready, 1'b1);
    tick();
    chk("t4_sfin_end", ctr_s_fin, 1'b0);

    // ---------------- test 5: reset mid-bundle ----------------
    put(32'h11111111, 1'b0);
    put(32'h22222222, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("t5_s_ready", s_ready, 1'b0);
    chk("t5_kfin", ctr_k_fin, 1'b0);
    chk("t5_sfin", ctr_s_fin, 1'b0);
    chk("t5_bit", ctr_bit, 32'h0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_m_valid", m_valid, 1'b0);
    chk("t5_m_data", m_data, 32'h0);
    chk("t5_m_count", m_count, 16'd0);
    rst_n = 1'b1;
    tick();
    chk("t5_clr_sfin", ctr_s_fin, 1'b1);
    put(32'h12345678, 1'b1);
    tick(); tick();
    chk("t5_mv", m_valid, 1'b1);
    chk("t5_data", m_data, 32'h12345678);
    chk("t5_count", m_count, 16'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;

    // ---------------- test 6: W=4 item cap ----------------
    tb_vec4 = 32'h00000000;
    chk("t6_ready", s_ready4, 1'b1);
    for (int n = 1; n <= 8; n++) begin
      put4(32'hFFFFFFFF, (n == 8));
      chk("t6_kfin", ctr_k_fin4, (n <= 6));
      chk("t6_err", err_ovf4, (n >= 7));
    end
    tick();
    chk("t6_tb_kfin", ctr_k_fin4, 1'b1);
    chk("t6_tb_bit", ctr_bit4, 32'h0);
    tick(); tick();
    chk("t6_mv", m_valid4, 1'b1);
    chk("t6_count", m_count4, 4'd6);
    chk("t6_data", m_data4, 32'hFFFFFFFF);
    chk("t6_kfin_total", kfin4_cnt, 7);
    m_ready4 = 1'b1;
    tick();
    m_ready4 = 1'b0;
    chk("t6_mv_drop", m_valid4, 1'b0);
    chk("t6_err_sticky", err_ovf4, 1'b1);
    chk("t6_w16_err_clean", err_ovf, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
